serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial N-bit unsigned subtractor: diff = a - b (mod 2^N), with borrow out.
//  Pairs with the N-bit ripple adder in the arithmetic datapath. It uses one full-subtractor
//  cell, which works through the operand one bit per clock, LSB first.
//  A start/busy/done handshake lets a controller issue operations and collect results.
// PARAMETERS
//  N    6    operand and result width in bits (N >= 2)
// PORTS
//  clk      in   1   rising-edge clock
//  rst_n    in   1   asynchronous, active-low reset
//  start    in   1   request; sampled only in IDLE
//  a        in   N   minuend; sampled on the cycle start is accepted
//  b        in   N   subtrahend; sampled on the cycle start is accepted
//  diff     out  N   registered result (a - b) mod 2^N
//  borrow   out  1   registered borrow out; 1 iff a < b (unsigned)
//  busy     out  1   high while in BUSY
//  done     out  1   one-cycle pulse in DONE; diff/borrow are valid from this cycle
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, count=0, internal shift regs=0,
//   borrow chain=0, diff=0, borrow=0, busy=0, done=0.
//  FSM states: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE, start=1 at edge k:
//    - latch a and b into shift registers
//    - bin=0, count=0, go to BUSY
//   IDLE, start=0: stay in IDLE.
//   BUSY: each edge processes bit i=count:
//    - d = a_i ^ b_i ^ bin
//    - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
//    - d shifts into the result shift register from the MSB side
//    - operand shift registers shift right; bin <= bout; count <= count+1
//   BUSY, count == N-1 (edge k+N):
//    - diff <= final result shift value
//    - borrow <= final bout
//    - go to DONE
//  DONE: done=1 for exactly one cycle, then go to IDLE. start is ignored in DONE.
//  Latency: start accepted at edge k; done high in the cycle after edge k+N.
//   Back-to-back period is N+2 cycles; start held high restarts at k+N+2.
//  start while BUSY or DONE: ignored; a/b changes then have no effect (operands are latched).
//  diff and borrow change only on the BUSY->DONE edge. They hold their value through IDLE and
//   the next BUSY until the next DONE, and they never show partial results.
//  busy = (state==BUSY); done = (state==DONE); both are decoded from registered state and are glitch-free.
//  count width is clog2(N). There is no wrap-around beyond N-1: the FSM leaves BUSY at N-1.
//  Reset mid-operation: aborts immediately, no done pulse, outputs return to reset values.
//  Result is modular: a=0, b=1 gives diff=2^N-1, borrow=1.
// TESTING (N=6)
//  1. a=45, b=18, one-cycle start -> busy for 6 cycles, then done=1 for one cycle;
//     diff=27, borrow=0.
//  2. a=5, b=9 -> diff=60, borrow=1.
//     a=0, b=1 -> diff=63, borrow=1.
//     a=63, b=63 -> diff=0, borrow=0.
//  3. Hold start=1 continuously with a=10, b=3 -> done pulses every 8 cycles with diff=7;
//     busy never overlaps done.
//  4. Change a/b and pulse start during BUSY -> ignored; result matches the originally
//     latched operands; exactly one done pulse.
//  5. Drive rst_n=0 on the 3rd BUSY cycle, then release -> no done pulse; diff=0, borrow=0,
//     busy=0; the next start computes correctly.
//  6. Random sweep over all 4096 (a,b) pairs -> diff == (a-b)&63 and borrow == (a<b);
//     diff stays stable between done pulses.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The controller drives start/a/b and collects diff/borrow on done.
interface serial_subtractor_if #(
    parameter int N = 6
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b,
        input  diff, borrow, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor, one full-subtractor cell, LSB first.
// Results are published only on the BUSY->DONE edge, never partially.
module serial_subtractor #(
    parameter int N = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  r_sh;
    logic [N-1:0]  diff_q;
    logic          bin;
    logic          borrow_q;
    logic          busy_q;
    logic          done_q;

    logic          ai;
    logic          bi;
    logic          d;
    logic          bout;
    logic [N-1:0]  r_next;

    assign ai     = a_sh[0];
    assign bi     = b_sh[0];
    assign d      = ai ^ bi ^ bin;
    assign bout   = (~ai & bi) | (~(ai ^ bi) & bin);
    assign r_next = {d, r_sh[N-1:1]};

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            bin      <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        bin    <= 1'b0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_sh  <= r_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    bin   <= bout;
                    count <= count + 1'b1;
                    // last bit: the shifted-in value is the complete result
                    if (count == CW'(N - 1)) begin
                        diff_q   <= r_next;
                        borrow_q <= bout;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: timing/arithmetic model checked every cycle,
// plus directed operations with literal expected results.
module tb_serial_subtractor;
    localparam int N    = 6;
    localparam int MASK = (1 << N) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Model: an accepted operation at edge k shows busy for N cycles,
    // then done for one cycle with the arithmetic result.
    bit active   = 1'b0;
    int e        = 0;
    int acc_k    = 0;
    int ma       = 0;
    int mb       = 0;
    int m_diff   = 0;
    int m_borrow = 0;
    int ph;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   = 1'b0;
            m_diff   = 0;
            m_borrow = 0;
        end else begin
            e++;
            ph = e - acc_k;
            if (active && ph == N) begin
                m_diff   = (ma - mb) & MASK;
                m_borrow = (ma < mb) ? 1 : 0;
            end
            if (active && ph == N + 1) begin
                active = 1'b0;
            end else if (!active && bus.start) begin
                active = 1'b1;
                acc_k  = e;
                ma     = int'(bus.a);
                mb     = int'(bus.b);
            end
        end
    end

    int done_cnt  = 0;
    int last_done = 0;
    int prev_done = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(bus.busy),
                (active && (e - acc_k) < N) ? 1 : 0);
            chk("done", int'(bus.done),
                (active && (e - acc_k) == N) ? 1 : 0);
            chk("diff", int'(bus.diff), m_diff);
            chk("borrow", int'(bus.borrow), m_borrow);
            chk("overlap", int'(bus.busy & bus.done), 0);
            if (bus.done) begin
                done_cnt++;
                prev_done = last_done;
                last_done = e;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input int av, input int bv,
                          input int ed, input int eb);
        int nb;
        int i;
        bit seen;
        bus.a     = N'(av);
        bus.b     = N'(bv);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nb   = 0;
        i    = 0;
        seen = 1'b0;
        while (!seen && i < N + 4) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) nb++;
                tick();
            end
            i++;
        end
        if (!seen) begin
            chk("op_timeout", 0, 1);
        end else begin
            chk("op_diff", int'(bus.diff), ed);
            chk("op_borrow", int'(bus.borrow), eb);
            chk("op_busy_len", nb, N);
        end
        tick();
    endtask

    initial begin
        int c0;
        int w;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.diff), 0);
        chk("rst_borrow", int'(bus.borrow), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        run_op(45, 18, 27, 0);
        run_op(5, 9, 60, 1);
        run_op(0, 1, 63, 1);
        run_op(63, 63, 0, 0);

        // start held high: back-to-back period
        bus.a     = 6'd10;
        bus.b     = 6'd3;
        bus.start = 1'b1;
        c0 = done_cnt;
        w  = 0;
        while (done_cnt < c0 + 3 && w < 40) begin
            tick();
            w++;
        end
        chk("hold_pulses", done_cnt - c0, 3);
        chk("hold_period", last_done - prev_done, N + 2);
        chk("hold_diff", int'(bus.diff), 7);
        bus.start = 1'b0;
        repeat (12) tick();

        // operands and start changed mid-operation are ignored
        bus.a     = 6'd45;
        bus.b     = 6'd18;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.a     = 6'd1;
        bus.b     = 6'd50;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c0 = done_cnt;
        repeat (12) tick();
        chk("ign_pulses", done_cnt - c0, 1);
        chk("ign_diff", int'(bus.diff), 27);
        chk("ign_borrow", int'(bus.borrow), 0);

        // reset on the third busy cycle
        bus.a     = 6'd20;
        bus.b     = 6'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_diff", int'(bus.diff), 0);
        chk("mid_rst_borrow", int'(bus.borrow), 0);
        c0 = done_cnt;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_no_done", done_cnt - c0, 0);
        run_op(20, 7, 13, 0);

        for (int av = 0; av <= MASK; av++) begin
            for (int bv = 0; bv <= MASK; bv++) begin
                run_op(av, bv, (av - bv) & MASK, (av < bv) ? 1 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
